// File: rtl/seq_loader_if.sv
// Byte-stream input and RAM write port of the sequence loader.
// master drives bytes and start; slave is the loader itself.
interface seq_loader_if #(
    parameter int AW = 9
);
    logic          start;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          byte_ready;
    logic [2:0]    din;
    logic          en_din;
    logic          we;
    logic [AW-1:0] addr_din;
    logic [AW-1:0] length;
    logic          busy;
    logic          done;
    logic          error;
    logic [7:0]    err_char;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, din, en_din, we, addr_din,
        input  length, busy, done, error, err_char
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, din, en_din, we, addr_din,
        output length, busy, done, error, err_char
    );
endinterface

// File: rtl/seq_loader.sv
// Encodes an ASCII nucleotide stream into 3-bit base codes and writes
// them into the sequence RAM, tracking length and malformed input.
module seq_loader #(
    parameter int       N       = 128,
    parameter int       BitAddr = $clog2(N + 1),
    parameter logic [2:0] G     = 3'b001,
    parameter logic [2:0] C     = 3'b110,
    parameter logic [2:0] A     = 3'b100,
    parameter logic [2:0] T     = 3'b011
) (
    input  logic        clk,
    input  logic        rst,
    seq_loader_if.slave bus
);
    localparam int AW = BitAddr + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE,
        ERR
    } state_t;

    state_t        state, state_n;
    logic [2:0]    din_q, din_n;
    logic          en_q, en_n;
    logic [AW-1:0] addr_q, addr_n;
    logic [AW-1:0] len_q, len_n;
    logic          done_q, done_n;
    logic          err_q, err_n;
    logic [7:0]    errc_q, errc_n;

    logic       is_g, is_c, is_a, is_t;
    logic       is_nuc, is_term;
    logic [2:0] code;

    assign is_g    = (bus.byte_in == 8'h47) || (bus.byte_in == 8'h67);
    assign is_c    = (bus.byte_in == 8'h43) || (bus.byte_in == 8'h63);
    assign is_a    = (bus.byte_in == 8'h41) || (bus.byte_in == 8'h61);
    assign is_t    = (bus.byte_in == 8'h54) || (bus.byte_in == 8'h74);
    assign is_nuc  = is_g || is_c || is_a || is_t;
    assign is_term = (bus.byte_in == 8'h0A) || (bus.byte_in == 8'h0D);

    always_comb begin
        code = 3'b000;
        unique case (1'b1)
            is_g:    code = G;
            is_c:    code = C;
            is_a:    code = A;
            is_t:    code = T;
            default: code = 3'b000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            din_q  <= '0;
            en_q   <= 1'b0;
            addr_q <= '0;
            len_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            errc_q <= '0;
        end else begin
            state  <= state_n;
            din_q  <= din_n;
            en_q   <= en_n;
            addr_q <= addr_n;
            len_q  <= len_n;
            done_q <= done_n;
            err_q  <= err_n;
            errc_q <= errc_n;
        end
    end

    always_comb begin
        state_n = state;
        din_n   = din_q;
        en_n    = 1'b0;
        addr_n  = addr_q;
        len_n   = len_q;
        done_n  = done_q;
        err_n   = err_q;
        errc_n  = errc_q;

        // start outranks any byte presented in the same cycle
        if (bus.start) begin
            state_n = LOAD;
            len_n   = '0;
            done_n  = 1'b0;
            err_n   = 1'b0;
            errc_n  = '0;
        end else if (state == LOAD && bus.byte_valid) begin
            if (is_nuc) begin
                if (len_q < AW'(N)) begin
                    en_n   = 1'b1;
                    din_n  = code;
                    addr_n = len_q;
                    len_n  = len_q + AW'(1);
                end else begin
                    state_n = ERR;
                    err_n   = 1'b1;
                    errc_n  = '0;
                end
            end else if (is_term) begin
                if (len_q != '0) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    state_n = ERR;
                    err_n   = 1'b1;
                    errc_n  = '0;
                end
            end else begin
                state_n = ERR;
                err_n   = 1'b1;
                errc_n  = bus.byte_in;
            end
        end
    end

    assign bus.din        = din_q;
    assign bus.en_din     = en_q;
    assign bus.we         = en_q;
    assign bus.addr_din   = addr_q;
    assign bus.length     = len_q;
    assign bus.busy       = (state == LOAD);
    assign bus.byte_ready = (state == LOAD);
    assign bus.done       = done_q;
    assign bus.error      = err_q;
    assign bus.err_char   = errc_q;
endmodule

// File: tb/tb_seq_loader.sv
// Directed bench for seq_loader: queue-based model checked every cycle,
// plus literal expectations for each scenario.
module tb_seq_loader;
    localparam int N  = 128;
    localparam int AW = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_loader_if #(.AW(AW)) bus ();

    seq_loader #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    // model: 0 idle, 1 loading, 2 done, 3 error
    int         phase;
    logic [2:0] mseq[$];
    logic       exp_en;
    logic [2:0] exp_din;
    int         exp_addr;
    logic       exp_done;
    logic       exp_err;
    logic [7:0] exp_ec;

    logic [2:0] wlog_din[$];
    int         wlog_addr[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        phase    = 0;
        mseq.delete();
        exp_en   = 1'b0;
        exp_din  = '0;
        exp_addr = 0;
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_ec   = '0;
    endtask

    task automatic model_update(logic s, logic v, logic [7:0] b);
        logic [7:0] u;
        logic [2:0] cd;
        bit         nuc;
        u   = (b >= 8'h61 && b <= 8'h7a) ? b - 8'd32 : b;
        nuc = 1'b1;
        cd  = 3'b000;
        case (u)
            8'h47:   cd = 3'b001;
            8'h43:   cd = 3'b110;
            8'h41:   cd = 3'b100;
            8'h54:   cd = 3'b011;
            default: nuc = 1'b0;
        endcase
        exp_en = 1'b0;
        if (s) begin
            phase = 1;
            mseq.delete();
            exp_done = 1'b0;
            exp_err  = 1'b0;
            exp_ec   = '0;
        end else if (phase == 1 && v) begin
            if (nuc) begin
                if (mseq.size() < N) begin
                    exp_addr = mseq.size();
                    exp_din  = cd;
                    exp_en   = 1'b1;
                    mseq.push_back(cd);
                end else begin
                    phase   = 3;
                    exp_err = 1'b1;
                    exp_ec  = '0;
                end
            end else if (b == 8'h0A || b == 8'h0D) begin
                if (mseq.size() > 0) begin
                    phase    = 2;
                    exp_done = 1'b1;
                end else begin
                    phase   = 3;
                    exp_err = 1'b1;
                    exp_ec  = '0;
                end
            end else begin
                phase   = 3;
                exp_err = 1'b1;
                exp_ec  = b;
            end
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("en_din",     bus.en_din,     exp_en);
            chk("we",         bus.we,         exp_en);
            chk("din",        bus.din,        exp_din);
            chk("addr_din",   bus.addr_din,   exp_addr);
            chk("length",     bus.length,     mseq.size());
            chk("busy",       bus.busy,       phase == 1);
            chk("byte_ready", bus.byte_ready, phase == 1);
            chk("done",       bus.done,       exp_done);
            chk("error",      bus.error,      exp_err);
            chk("err_char",   bus.err_char,   exp_ec);
            if (bus.en_din === 1'b1) begin
                wlog_din.push_back(bus.din);
                wlog_addr.push_back(int'(bus.addr_din));
            end
        end
    end

    task automatic step(logic s, logic v, logic [7:0] b);
        bus.start      = s;
        bus.byte_valid = v;
        bus.byte_in    = b;
        @(posedge clk);
        if (!rst) model_update(s, v, b);
        #1;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
    endtask

    task automatic begin_load();
        wlog_din.delete();
        wlog_addr.delete();
        step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic send(string str, int gap);
        for (int i = 0; i < str.len(); i++) begin
            step(1'b0, 1'b1, str[i]);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_en_din",  bus.en_din,     0);
        chk("rst_we",      bus.we,         0);
        chk("rst_din",     bus.din,        0);
        chk("rst_addr",    bus.addr_din,   0);
        chk("rst_length",  bus.length,     0);
        chk("rst_busy",    bus.busy,       0);
        chk("rst_ready",   bus.byte_ready, 0);
        chk("rst_done",    bus.done,       0);
        chk("rst_error",   bus.error,      0);
        chk("rst_errchar", bus.err_char,   0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] d1[5];
        logic [2:0] d2[4];
        rst            = 1'b0;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        model_reset();
        #2;
        do_reset();
        run = 1'b1;

        begin_load();
        send("GATGC\n", 0);
        d1 = '{3'b001, 3'b100, 3'b011, 3'b001, 3'b110};
        chk("t1_nwrites", wlog_din.size(), 5);
        for (int i = 0; i < 5 && i < wlog_din.size(); i++) begin
            chk("t1_addr", wlog_addr[i], i);
            chk("t1_din",  wlog_din[i],  d1[i]);
        end
        chk("t1_done",  bus.done,   1);
        chk("t1_len",   bus.length, 5);
        chk("t1_error", bus.error,  0);

        begin_load();
        send("gatc\r", 2);
        d2 = '{3'b001, 3'b100, 3'b011, 3'b110};
        chk("t2_nwrites", wlog_din.size(), 4);
        for (int i = 0; i < 4 && i < wlog_din.size(); i++) begin
            chk("t2_addr", wlog_addr[i], i);
            chk("t2_din",  wlog_din[i],  d2[i]);
        end
        chk("t2_done", bus.done,   1);
        chk("t2_len",  bus.length, 4);

        begin_load();
        send("GAX", 0);
        chk("t3_error",   bus.error,    1);
        chk("t3_errchar", bus.err_char, 8'h58);
        chk("t3_len",     bus.length,   2);
        chk("t3_ready",   bus.byte_ready, 0);
        send("T", 0);
        chk("t3_nwrites", wlog_din.size(), 2);
        chk("t3_len2",    bus.length, 2);

        begin_load();
        for (int i = 0; i < N; i++) step(1'b0, 1'b1, 8'h41);
        step(1'b0, 1'b1, 8'h43);
        chk("t4_error",   bus.error,    1);
        chk("t4_errchar", bus.err_char, 0);
        chk("t4_len",     bus.length,   128);
        chk("t4_nwrites", wlog_din.size(), 128);
        if (wlog_addr.size() > 0)
            chk("t4_lastaddr", wlog_addr[$], 127);

        begin_load();
        for (int i = 0; i < N; i++) step(1'b0, 1'b1, 8'h61);
        send("\n", 0);
        chk("t4b_done", bus.done,   1);
        chk("t4b_len",  bus.length, 128);
        chk("t4b_nwr",  wlog_din.size(), 128);

        begin_load();
        send("\n", 0);
        chk("t5_error",   bus.error,    1);
        chk("t5_errchar", bus.err_char, 0);
        chk("t5_len",     bus.length,   0);
        wlog_din.delete();
        wlog_addr.delete();
        step(1'b1, 1'b1, 8'h47);
        send("T\n", 0);
        chk("t5_done",    bus.done,   1);
        chk("t5_len2",    bus.length, 1);
        chk("t5_nwrites", wlog_din.size(), 1);
        if (wlog_din.size() > 0) begin
            chk("t5_addr", wlog_addr[0], 0);
            chk("t5_din",  wlog_din[0],  3'b011);
        end

        begin_load();
        send("GA", 0);
        chk("t6_strobe", bus.en_din, 1);
        do_reset();
        begin_load();
        send("C\n", 0);
        chk("t6_nwrites", wlog_din.size(), 1);
        if (wlog_din.size() > 0) begin
            chk("t6_addr", wlog_addr[0], 0);
            chk("t6_din",  wlog_din[0],  3'b110);
        end
        chk("t6_len",  bus.length, 1);
        chk("t6_done", bus.done,   1);

        step(1'b0, 1'b0, 8'h00);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
